fetch_stage: RTL and testbench

- Instruction fetch stage; sits directly upstream of the fetch/decode pipeline register and drives its instr_f / pc_f inputs.
- Generates sequential PCs and issues requests to instruction memory over a valid/ready request channel with an in-order, variable-latency response channel.
- Buffers returned instructions with their PCs, holds them under stall, and discards stale responses after a redirect (branch/jump/trap).

---
 rtl/fetch_stage.sv | 107 ++++++++++
 tb/tb_fetch_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch: sequential PC generation, credit-limited imem requests,
// in-order response buffering with redirect flush and stale-response drop.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic        valid_f
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  logic [31:0]   req_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic [AW-1:0] pq_wr;
  logic [AW-1:0] pq_rd;
  logic [AW-1:0] ib_wr;
  logic [AW-1:0] ib_rd;
  logic [31:0]   pq_mem [BUF_DEPTH];
  fetch_t        ib_mem [BUF_DEPTH];
  logic [CW:0]   occ;
  logic          hs;
  logic          drop;
  logic          push;
  logic          pop;
  fetch_t        head;
  logic          unused_lsb;

  // Credits cover both buffered and outstanding words, so the buffer can't overflow
  assign occ = {1'b0, inflight} + {1'b0, count};
  assign imem_req_valid = !reset && !redirect_valid &&
                          (occ < (CW+1)'(BUF_DEPTH));
  assign imem_req_addr = req_pc;
  assign hs = imem_req_valid && imem_req_ready;

  assign drop = redirect_valid || (drop_cnt != '0);
  assign push = imem_rsp_valid && !drop;
  assign valid_f = count != '0;
  assign pop = valid_f && !stall_f && !redirect_valid;

  assign head = ib_mem[ib_rd];
  assign instr_f = valid_f ? head.instr : '0;
  assign pc_f = valid_f ? head.pc : '0;
  assign unused_lsb = ^redirect_pc[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_pc <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      count <= '0;
      pq_wr <= '0;
      pq_rd <= '0;
      ib_wr <= '0;
      ib_rd <= '0;
    end else begin
      inflight <= inflight + CW'(hs) - CW'(imem_rsp_valid);
      if (hs) begin
        pq_wr <= pq_wr + 1'b1;
        req_pc <= req_pc + 32'd4;
      end
      if (imem_rsp_valid) pq_rd <= pq_rd + 1'b1;
      // pc FIFO survives a redirect so stale responses still pop their slot
      if (redirect_valid) begin
        req_pc <= {redirect_pc[31:2], 2'b00};
        drop_cnt <= inflight - CW'(imem_rsp_valid);
        count <= '0;
        ib_wr <= '0;
        ib_rd <= '0;
      end else begin
        if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        if (push) ib_wr <= ib_wr + 1'b1;
        if (pop) ib_rd <= ib_rd + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (hs) pq_mem[pq_wr] <= req_pc;
    if (push) ib_mem[ib_wr] <= '{pc: pq_mem[pq_rd], instr: imem_rsp_data};
  end

  rsp_without_req: assert property (
    @(posedge clk) disable iff (reset) imem_rsp_valid |-> inflight != '0
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a queue-based reference model
// with an in-order variable-latency instruction memory.
module tb_fetch_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_f;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic        valid_f;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .stall_f(stall_f),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .instr_f(instr_f),
    .pc_f(pc_f),
    .valid_f(valid_f)
  );

  int n_vec;
  int n_err;
  int cyc;
  int p_ready;
  int p_rsp;
  int p_stall;
  int p_redir;
  logic        f_redir;
  logic [31:0] f_pc;
  logic        f_rst;

  logic [31:0] m_req_pc;
  int          m_inflight;
  int          m_drop;
  logic [63:0] bufq[$];
  logic [31:0] memq_a[$];
  int          memq_t[$];

  logic        last_hs;
  logic [31:0] last_addr;
  logic        obs_valid;
  logic [31:0] obs_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_req_pc = 32'h0;
    m_inflight = 0;
    m_drop = 0;
    bufq.delete();
    memq_a.delete();
    memq_t.delete();
  endtask

  function automatic logic m_req_valid();
    return !reset && !redirect_valid && (m_inflight + bufq.size() < DEPTH);
  endfunction

  task automatic set_mix(input int r, input int s, input int st, input int rd);
    p_ready = r;
    p_rsp = s;
    p_stall = st;
    p_redir = rd;
  endtask

  task automatic cycle();
    logic        hs;
    logic        mv;
    logic [31:0] a;
    logic [31:0] exp_i;
    logic [31:0] exp_p;
    @(negedge clk);
    reset = f_rst;
    if (f_rst) model_reset();
    redirect_valid = f_redir || ($urandom_range(99) < p_redir);
    redirect_pc = f_redir ? f_pc : $urandom;
    stall_f = $urandom_range(99) < p_stall;
    imem_req_ready = $urandom_range(99) < p_ready;
    imem_rsp_valid = !f_rst && memq_a.size() > 0 &&
                     (cyc - memq_t[0] >= 1) && ($urandom_range(99) < p_rsp);
    imem_rsp_data = imem_rsp_valid ? mem_word(memq_a[0]) : $urandom;
    f_redir = 1'b0;
    #1;
    mv = bufq.size() > 0;
    exp_i = 32'h0;
    exp_p = 32'h0;
    if (mv) begin
      exp_i = bufq[0][31:0];
      exp_p = bufq[0][63:32];
    end
    check("req_valid", 32'(imem_req_valid), 32'(m_req_valid()));
    check("req_addr", imem_req_addr, m_req_pc);
    check("valid_f", 32'(valid_f), 32'(mv));
    check("instr_f", instr_f, exp_i);
    check("pc_f", pc_f, exp_p);
    last_hs = imem_req_valid && imem_req_ready;
    last_addr = imem_req_addr;
    obs_valid = valid_f;
    obs_pc = pc_f;
    @(posedge clk);
    if (!reset) begin
      hs = m_req_valid() && imem_req_ready;
      a = 32'h0;
      if (imem_rsp_valid) begin
        a = memq_a.pop_front();
        void'(memq_t.pop_front());
      end
      if (redirect_valid) begin
        bufq.delete();
        m_drop = m_inflight - (imem_rsp_valid ? 1 : 0);
        m_req_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (mv && !stall_f) void'(bufq.pop_front());
        if (imem_rsp_valid) begin
          if (m_drop > 0) m_drop--;
          else bufq.push_back({a, imem_rsp_data});
        end
        if (hs) begin
          memq_a.push_back(m_req_pc);
          memq_t.push_back(cyc);
          m_req_pc = m_req_pc + 32'd4;
        end
      end
      m_inflight += (hs ? 1 : 0) - (imem_rsp_valid ? 1 : 0);
    end
    cyc++;
  endtask

  task automatic wait_first_valid(input string tag, input logic [31:0] exp);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (obs_valid) begin
        found = 1'b1;
        check(tag, obs_pc, exp);
      end
    end
    if (!found) check({tag, "_timeout"}, 32'h0, 32'h1);
  endtask

  initial begin
    logic seen;
    reset = 1'b1;
    stall_f = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    f_redir = 1'b0;
    f_pc = 32'h0;
    f_rst = 1'b1;
    cyc = 0;
    n_vec = 0;
    n_err = 0;
    model_reset();
    set_mix(100, 100, 0, 0);
    repeat (3) cycle();
    f_rst = 1'b0;
    cycle();
    check("first_req_addr", last_addr, 32'h0);
    repeat (20) cycle();

    p_stall = 100;
    repeat (5) cycle();
    p_stall = 0;
    repeat (6) cycle();

    p_ready = 0;
    repeat (3) cycle();
    p_ready = 100;
    repeat (4) cycle();

    // redirect with two requests outstanding
    f_rst = 1'b1;
    cycle();
    f_rst = 1'b0;
    p_rsp = 0;
    repeat (2) cycle();
    f_redir = 1'b1;
    f_pc = 32'h0000_0103;
    cycle();
    p_rsp = 100;
    cycle();
    check("addr_after_redirect", last_addr, 32'h0000_0100);
    wait_first_valid("first_pc_after_redirect", 32'h0000_0100);

    // redirect coinciding with a response
    f_rst = 1'b1;
    cycle();
    f_rst = 1'b0;
    p_rsp = 0;
    repeat (2) cycle();
    p_rsp = 100;
    f_redir = 1'b1;
    f_pc = 32'h0000_0040;
    cycle();
    wait_first_valid("first_pc_after_rsp_redirect", 32'h0000_0040);

    // address wrap
    repeat (4) cycle();
    f_redir = 1'b1;
    f_pc = 32'hFFFF_FFFE;
    cycle();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      if (last_hs && last_addr == 32'hFFFF_FFFC) seen = 1'b1;
    end
    if (!seen) check("wrap_issue_timeout", 32'h0, 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      if (last_hs) begin
        seen = 1'b1;
        check("wrap_next_addr", last_addr, 32'h0);
      end
    end
    if (!seen) check("wrap_next_timeout", 32'h0, 32'h1);

    // reset with a full buffer
    p_stall = 100;
    repeat (6) cycle();
    f_rst = 1'b1;
    cycle();
    check("valid_in_reset", 32'(obs_valid), 32'h0);
    f_rst = 1'b0;
    p_stall = 0;
    cycle();
    check("addr_after_mid_reset", last_addr, 32'h0);

    for (int blk = 0; blk < 30; blk++) begin
      set_mix($urandom_range(100, 20), $urandom_range(100, 20),
              $urandom_range(70, 0), $urandom_range(8, 0));
      for (int i = 0; i < 100; i++) begin
        f_rst = ($urandom_range(299) == 0);
        cycle();
      end
    end
    f_rst = 1'b0;
    repeat (2) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
